// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target controller and its helpers.
package i2c_pkg;

    localparam int   I2C_ADDR_W   = 7;
    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_LOAD,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_IGNORE
    } i2c_tgt_state_t;

endpackage

// File: rtl/i2c_bus_cond.sv
// Synchronizes sda/scl and detects scl edges plus START/STOP conditions.
module i2c_bus_cond #(
    parameter int SYNC_STAGES = 2
) (
    input  logic system_clock,
    input  logic reset,
    input  logic sda_i,
    input  logic scl_i,
    output logic sda_sync,
    output logic scl_sync,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] sda_pipe;
    logic [SYNC_STAGES-1:0] scl_pipe;
    logic                   sda_prev;
    logic                   scl_prev;

    // Preset to 1 so a reset never looks like an edge on an idle bus.
    always_ff @(posedge system_clock) begin
        if (reset) begin
            sda_pipe <= '1;
            scl_pipe <= '1;
            sda_prev <= 1'b1;
            scl_prev <= 1'b1;
        end else begin
            sda_pipe <= {sda_pipe[SYNC_STAGES-2:0], sda_i};
            scl_pipe <= {scl_pipe[SYNC_STAGES-2:0], scl_i};
            sda_prev <= sda_sync;
            scl_prev <= scl_sync;
        end
    end

    assign sda_sync  = sda_pipe[SYNC_STAGES-1];
    assign scl_sync  = scl_pipe[SYNC_STAGES-1];
    assign scl_rise  = scl_sync & ~scl_prev;
    assign scl_fall  = ~scl_sync & scl_prev;
    assign start_det = scl_sync & scl_prev & sda_prev & ~sda_sync;
    assign stop_det  = scl_sync & scl_prev & ~sda_prev & sda_sync;

endmodule

// File: rtl/i2c_target_ctrl.sv
// 7-bit-address I2C target: decodes frames, exchanges bytes with local logic, stretches scl on reads.
module i2c_target_ctrl
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h42,
    parameter int                    HOLD_CYCLES = 4,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic       system_clock,
    input  logic       reset,
    input  logic       sda_i,
    input  logic       scl_i,
    output logic       sda_oe,
    output logic       scl_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       bus_start,
    output logic       bus_stop,
    output logic       busy
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    logic sda_sync, scl_sync, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_cond #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_bus_cond (
        .system_clock(system_clock),
        .reset       (reset),
        .sda_i       (sda_i),
        .scl_i       (scl_i),
        .sda_sync    (sda_sync),
        .scl_sync    (scl_sync),
        .scl_rise    (scl_rise),
        .scl_fall    (scl_fall),
        .start_det   (start_det),
        .stop_det    (stop_det)
    );

    i2c_tgt_state_t state, state_n;
    logic [3:0]        bit_cnt, bit_cnt_n;
    logic [7:0]        shift_reg, shift_n;
    logic [HOLD_W-1:0] hold_cnt;
    logic              drive_tick;
    logic              sda_oe_n, scl_oe_n, rx_valid_n, tx_ready_n, busy_n;
    logic [7:0]        rx_data_n;

    // sda may only change once the hold window after an scl fall has elapsed.
    always_ff @(posedge system_clock) begin
        if (reset) begin
            hold_cnt <= '0;
        end else if (scl_fall) begin
            hold_cnt <= HOLD_W'(HOLD_CYCLES);
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
        end
    end

    assign drive_tick = (hold_cnt == HOLD_W'(1));

    always_ff @(posedge system_clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            sda_oe    <= 1'b0;
            scl_oe    <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            tx_ready  <= 1'b0;
            bus_start <= 1'b0;
            bus_stop  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shift_reg <= shift_n;
            sda_oe    <= sda_oe_n;
            scl_oe    <= scl_oe_n;
            rx_data   <= rx_data_n;
            rx_valid  <= rx_valid_n;
            tx_ready  <= tx_ready_n;
            bus_start <= start_det;
            bus_stop  <= stop_det;
            busy      <= busy_n;
        end
    end

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        shift_n    = shift_reg;
        sda_oe_n   = sda_oe;
        scl_oe_n   = scl_oe;
        rx_data_n  = rx_data;
        rx_valid_n = 1'b0;
        tx_ready_n = 1'b0;
        busy_n     = busy;

        if (start_det) begin
            state_n   = ST_ADDR;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
            scl_oe_n  = 1'b0;
            busy_n    = 1'b1;
        end else if (stop_det) begin
            state_n   = ST_IDLE;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
            scl_oe_n  = 1'b0;
            busy_n    = 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_IGNORE: begin
                    sda_oe_n = 1'b0;
                    scl_oe_n = 1'b0;
                end
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_n = {shift_reg[6:0], sda_sync};
                        if (bit_cnt == 4'd7) begin
                            bit_cnt_n = '0;
                            // Address 0 (general call) is deliberately never acknowledged.
                            if (shift_n[7:1] == TARGET_ADDR && shift_n[7:1] != '0) begin
                                state_n = ST_ADDR_ACK;
                            end else begin
                                state_n = ST_IGNORE;
                            end
                        end else begin
                            bit_cnt_n = bit_cnt + 4'd1;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (drive_tick) begin
                        sda_oe_n = 1'b1;
                    end
                    if (scl_rise) begin
                        state_n = (shift_reg[0] == I2C_RW_WRITE) ? ST_WR_DATA : ST_RD_LOAD;
                    end
                end
                ST_WR_DATA: begin
                    if (drive_tick) begin
                        sda_oe_n = 1'b0;
                    end
                    if (scl_rise) begin
                        shift_n = {shift_reg[6:0], sda_sync};
                        if (bit_cnt == 4'd7) begin
                            bit_cnt_n  = '0;
                            rx_data_n  = shift_n;
                            rx_valid_n = 1'b1;
                            state_n    = ST_WR_ACK;
                        end else begin
                            bit_cnt_n = bit_cnt + 4'd1;
                        end
                    end
                end
                ST_WR_ACK: begin
                    if (drive_tick) begin
                        sda_oe_n = 1'b1;
                    end
                    if (scl_rise) begin
                        state_n = ST_WR_DATA;
                    end
                end
                ST_RD_LOAD: begin
                    if (drive_tick) begin
                        sda_oe_n = 1'b0;
                    end
                    if (scl_fall || scl_oe) begin
                        if (tx_valid) begin
                            shift_n    = tx_data;
                            tx_ready_n = 1'b1;
                            scl_oe_n   = 1'b0;
                            bit_cnt_n  = '0;
                            state_n    = ST_RD_DATA;
                            // After a long stretch the hold window is gone, so present bit 7 now.
                            if (scl_oe && (hold_cnt == '0 || drive_tick)) begin
                                sda_oe_n = ~tx_data[7];
                            end
                        end else begin
                            scl_oe_n = 1'b1;
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (drive_tick) begin
                        sda_oe_n = ~shift_reg[7];
                    end
                    if (scl_rise) begin
                        shift_n = {shift_reg[6:0], 1'b0};
                        if (bit_cnt == 4'd7) begin
                            bit_cnt_n = '0;
                            state_n   = ST_RD_ACK;
                        end else begin
                            bit_cnt_n = bit_cnt + 4'd1;
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (drive_tick) begin
                        sda_oe_n = 1'b0;
                    end
                    if (scl_rise) begin
                        state_n = sda_sync ? ST_IGNORE : ST_RD_LOAD;
                    end
                end
                default: begin
                    state_n  = ST_IDLE;
                    sda_oe_n = 1'b0;
                    scl_oe_n = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target_ctrl.sv
// Directed self-checking bench: a bit-banged open-drain controller drives the target.
module tb_i2c_target_ctrl;

    localparam int Q = 10;

    logic       system_clock = 1'b0;
    logic       reset        = 1'b1;
    logic       ctrl_sda_low = 1'b0;
    logic       ctrl_scl_low = 1'b0;
    logic       sda_i, scl_i;
    logic       sda_oe, scl_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, bus_start, bus_stop, busy;

    int checks   = 0;
    int failures = 0;

    int rx_cnt = 0, tx_cnt = 0, start_cnt = 0, stop_cnt = 0, sda_oe_cycles = 0, bad_release = 0;
    logic [7:0] rx_log[$];
    logic       scl_oe_prev = 1'b0;

    assign sda_i = ~(ctrl_sda_low | sda_oe);
    assign scl_i = ~(ctrl_scl_low | scl_oe);

    always #5 system_clock = ~system_clock;

    i2c_target_ctrl #(
        .TARGET_ADDR(7'h42),
        .HOLD_CYCLES(4),
        .SYNC_STAGES(2)
    ) dut (
        .system_clock(system_clock),
        .reset       (reset),
        .sda_i       (sda_i),
        .scl_i       (scl_i),
        .sda_oe      (sda_oe),
        .scl_oe      (scl_oe),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .bus_start   (bus_start),
        .bus_stop    (bus_stop),
        .busy        (busy)
    );

    // Pulse and activity counters observed between clock edges.
    always @(negedge system_clock) begin
        if (rx_valid) begin
            rx_cnt++;
            rx_log.push_back(rx_data);
        end
        if (tx_ready)  tx_cnt++;
        if (bus_start) start_cnt++;
        if (bus_stop)  stop_cnt++;
        if (sda_oe)    sda_oe_cycles++;
        if (scl_oe_prev && !scl_oe && !tx_ready) bad_release++;
        scl_oe_prev = scl_oe;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge system_clock);
    endtask

    task automatic release_scl();
        int waited = 0;
        ctrl_scl_low = 1'b0;
        while (scl_i !== 1'b1 && waited < 2000) begin
            @(negedge system_clock);
            waited++;
        end
        if (scl_i !== 1'b1) checkOutput("scl_release_timeout", 32'(scl_i), 1);
    endtask

    // One scl period starting and ending just after scl is pulled low.
    task automatic applyStimulus(input logic b, output logic sampled);
        wait_clk(Q);
        ctrl_sda_low = ~b;
        wait_clk(Q);
        release_scl();
        wait_clk(Q);
        sampled = sda_i;
        wait_clk(Q);
        ctrl_scl_low = 1'b1;
    endtask

    task automatic i2c_start();
        ctrl_sda_low = 1'b1;
        wait_clk(2 * Q);
        ctrl_scl_low = 1'b1;
    endtask

    task automatic i2c_rstart();
        wait_clk(Q);
        ctrl_sda_low = 1'b0;
        wait_clk(Q);
        release_scl();
        wait_clk(Q);
        ctrl_sda_low = 1'b1;
        wait_clk(Q);
        ctrl_scl_low = 1'b1;
    endtask

    task automatic i2c_stop();
        wait_clk(Q);
        ctrl_sda_low = 1'b1;
        wait_clk(Q);
        release_scl();
        wait_clk(Q);
        ctrl_sda_low = 1'b0;
        wait_clk(2 * Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) applyStimulus(d[i], s);
        applyStimulus(1'b1, s);
        acked = ~s;
    endtask

    task automatic read_byte(input logic give_ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            applyStimulus(1'b1, s);
            d[i] = s;
        end
        applyStimulus(~give_ack, s);
    endtask

    task automatic wait_tx_ready(input int budget, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge system_clock);
            if (tx_ready) seen = 1'b1;
        end
    endtask

    initial begin
        logic       ack;
        logic       seen;
        logic [7:0] d0, d1;
        int         rx0, tx0, st0, sp0, oe0, stretch_cnt;

        $display("[TB] reset");
        wait_clk(5);
        checkOutput("reset_sda_oe", 32'(sda_oe), 0);
        checkOutput("reset_scl_oe", 32'(scl_oe), 0);
        checkOutput("reset_rx_data", 32'(rx_data), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_pulses", {28'd0, rx_valid, tx_ready, bus_start, bus_stop}, 0);
        reset = 1'b0;
        wait_clk(10);

        $display("[TB] write frame");
        rx0 = rx_cnt; st0 = start_cnt; sp0 = stop_cnt;
        i2c_start();
        send_byte(8'h84, ack);
        checkOutput("wr_addr_ack", 32'(ack), 1);
        checkOutput("wr_busy", 32'(busy), 1);
        send_byte(8'hA5, ack);
        checkOutput("wr_data0_ack", 32'(ack), 1);
        send_byte(8'h3C, ack);
        checkOutput("wr_data1_ack", 32'(ack), 1);
        i2c_stop();
        checkOutput("wr_rx_pulses", 32'(rx_cnt - rx0), 2);
        checkOutput("wr_rx_first", 32'(rx_log[rx0]), 32'h A5);
        checkOutput("wr_rx_second", 32'(rx_log[rx0 + 1]), 32'h3C);
        checkOutput("wr_start_pulses", 32'(start_cnt - st0), 1);
        checkOutput("wr_stop_pulses", 32'(stop_cnt - sp0), 1);
        checkOutput("wr_busy_after_stop", 32'(busy), 0);

        $display("[TB] read frame");
        tx0 = tx_cnt;
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        i2c_start();
        send_byte(8'h85, ack);
        checkOutput("rd_addr_ack", 32'(ack), 1);
        fork
            begin
                read_byte(1'b1, d0);
                read_byte(1'b0, d1);
            end
            begin
                wait_tx_ready(2000, seen);
                checkOutput("rd_first_tx_ready", 32'(seen), 1);
                tx_data = 8'hC3;
            end
        join
        checkOutput("rd_byte0", 32'(d0), 32'h5A);
        checkOutput("rd_byte1", 32'(d1), 32'hC3);
        wait_clk(2);
        checkOutput("rd_sda_released_after_nack", 32'(sda_oe), 0);
        i2c_stop();
        tx_valid = 1'b0;
        checkOutput("rd_tx_ready_pulses", 32'(tx_cnt - tx0), 2);

        $display("[TB] address mismatch");
        rx0 = rx_cnt; oe0 = sda_oe_cycles;
        i2c_start();
        send_byte(8'hA0, ack);
        checkOutput("mm_addr_nack", 32'(ack), 0);
        checkOutput("mm_busy_mid", 32'(busy), 1);
        send_byte(8'h11, ack);
        checkOutput("mm_data_nack", 32'(ack), 0);
        checkOutput("mm_busy_end", 32'(busy), 1);
        i2c_stop();
        checkOutput("mm_sda_oe_cycles", 32'(sda_oe_cycles - oe0), 0);
        checkOutput("mm_rx_pulses", 32'(rx_cnt - rx0), 0);

        $display("[TB] clock stretch");
        tx0 = tx_cnt; stretch_cnt = 0;
        i2c_start();
        send_byte(8'h85, ack);
        checkOutput("st_addr_ack", 32'(ack), 1);
        fork
            read_byte(1'b0, d0);
            begin
                for (int i = 0; i < 200 && !scl_oe; i++) @(negedge system_clock);
                checkOutput("st_scl_oe_asserted", 32'(scl_oe), 1);
                for (int i = 0; i < 200; i++) begin
                    @(negedge system_clock);
                    if (scl_oe) stretch_cnt++;
                end
                tx_data  = 8'h77;
                tx_valid = 1'b1;
                wait_tx_ready(50, seen);
                checkOutput("st_tx_ready_seen", 32'(seen), 1);
                checkOutput("st_scl_released_with_ready", 32'(scl_oe), 0);
                tx_valid = 1'b0;
            end
        join
        i2c_stop();
        checkOutput("st_stretch_cycles", 32'(stretch_cnt), 200);
        checkOutput("st_byte", 32'(d0), 32'h77);
        checkOutput("st_tx_ready_pulses", 32'(tx_cnt - tx0), 1);
        checkOutput("st_bad_release", 32'(bad_release), 0);

        $display("[TB] repeated start");
        rx0 = rx_cnt; st0 = start_cnt;
        tx_data  = 8'hE1;
        tx_valid = 1'b1;
        i2c_start();
        send_byte(8'h84, ack);
        checkOutput("rs_wr_addr_ack", 32'(ack), 1);
        send_byte(8'h10, ack);
        checkOutput("rs_wr_data_ack", 32'(ack), 1);
        i2c_rstart();
        send_byte(8'h85, ack);
        checkOutput("rs_rd_addr_ack", 32'(ack), 1);
        read_byte(1'b0, d0);
        i2c_stop();
        tx_valid = 1'b0;
        checkOutput("rs_rx_data", 32'(rx_data), 32'h10);
        checkOutput("rs_rx_pulses", 32'(rx_cnt - rx0), 1);
        checkOutput("rs_start_pulses", 32'(start_cnt - st0), 2);
        checkOutput("rs_read_byte", 32'(d0), 32'hE1);

        $display("[TB] reset mid-byte");
        rx0 = rx_cnt;
        i2c_start();
        send_byte(8'h84, ack);
        checkOutput("rm_addr_ack", 32'(ack), 1);
        applyStimulus(1'b1, ack);
        applyStimulus(1'b0, ack);
        applyStimulus(1'b0, ack);
        applyStimulus(1'b1, ack);
        reset = 1'b1;
        wait_clk(1);
        checkOutput("rm_sda_oe", 32'(sda_oe), 0);
        checkOutput("rm_scl_oe", 32'(scl_oe), 0);
        checkOutput("rm_busy", 32'(busy), 0);
        checkOutput("rm_rx_data_cleared", 32'(rx_data), 0);
        wait_clk(3);
        reset = 1'b0;
        ctrl_sda_low = 1'b0;
        wait_clk(Q);
        ctrl_scl_low = 1'b0;
        wait_clk(4 * Q);
        checkOutput("rm_no_rx_pulse", 32'(rx_cnt - rx0), 0);
        i2c_start();
        send_byte(8'h84, ack);
        checkOutput("rm_new_addr_ack", 32'(ack), 1);
        send_byte(8'h99, ack);
        checkOutput("rm_new_data_ack", 32'(ack), 1);
        i2c_stop();
        checkOutput("rm_new_rx_data", 32'(rx_data), 32'h99);
        checkOutput("rm_new_rx_pulses", 32'(rx_cnt - rx0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
